// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the instruction-memory responder.
//   ADDR_W_DEF / INSTR_W_DEF : default PC and instruction widths
//   NOP_ENC                  : instruction encoding of a no-op (cleared memory)
//   state_e                  : responder FSM encoding
package cpu_pkg;
  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;
  localparam int NOP_ENC     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/imem_array.sv
// DEPTH x INSTR_W instruction storage.
//   clk, rst_n   : clock, async active-low clear (all words -> NOP)
//   we/waddr/wdata : single write port; caller only writes in-range addresses
//   raddr/rdata  : combinational read; out-of-range addresses read NOP
module imem_array import cpu_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [DEPTH-1:0][INSTR_W-1:0] mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             mem[g] <= INSTR_W'(NOP_ENC);
      else if (we && waddr == ADDR_W'(g))     mem[g] <= wdata;
    end
  end

  // Compare-based mux keeps out-of-range reads at NOP without indexing past DEPTH.
  always_comb begin
    rdata = INSTR_W'(NOP_ENC);
    for (int i = 0; i < DEPTH; i++)
      if (raddr == ADDR_W'(i)) rdata = mem[i];
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory side of the CPU fetch interface.
//   clk, reset            : clock, async active-low reset
//   req_valid/ready/addr  : fetch request handshake (PC)
//   rsp_valid/ready       : response handshake; rsp_instr/addr/err held until taken
//   rsp_err               : fetch address >= DEPTH, rsp_instr forced to NOP
//   load_en/addr/data     : program write port, honoured only in IDLE
//   load_drop             : one-cycle pulse, a load was ignored (busy or out of range)
// A fetch accepted at the edge ending cycle N responds in cycle N+1+WAIT_CYCLES.
module imem_responder import cpu_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic               rsp_err,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_drop
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WC      = 4'(WAIT_CYCLES);

  state_e              state, state_nx;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q, rd_addr;
  logic [INSTR_W-1:0]  rd_data;
  logic                idle, accept, load_ok, rd_ok, wr_en, rsp_load;

  assign idle      = (state == IDLE);
  // Gated by reset so the port reads 0 while reset is held.
  assign req_ready = idle & reset & ~load_en;
  assign accept    = req_valid & req_ready;
  assign load_ok   = {1'b0, load_addr} < DEPTH_L;
  assign wr_en     = idle & load_en & load_ok;
  // With zero wait states the response is captured at the accepting edge,
  // so the read port must see the live request address in IDLE.
  assign rd_addr   = idle ? req_addr : addr_q;
  assign rd_ok     = {1'b0, rd_addr} < DEPTH_L;
  assign rsp_load  = (accept & (WC == 4'd0)) | ((state == WAIT) & (cnt == 4'd1));

  imem_array #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (WC == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      load_drop <= 1'b0;
    end else begin
      state     <= state_nx;
      load_drop <= load_en & ~(idle & load_ok);
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= WC;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= rd_addr;
        rsp_err   <= ~rd_ok;
        rsp_instr <= rd_ok ? rd_data : INSTR_W'(NOP_ENC);
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the CPU instruction-fetch interface.
- Accepts fetch requests (PC address) over a valid/ready handshake and returns the stored instruction after a programmable wait-state latency.
- Has a load port so benches and boot logic can write the program before or between fetches.
- Sits between the CPU fetch stage and program storage, and replaces a purely combinational instruction ROM.

Parameters:
- ADDR_W, 4: fetch/load address width (matches the CPU PC width).
- INSTR_W, 8: instruction word width.
- DEPTH, 16: number of instruction words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 1: extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  CPU presents a fetch address.
- req_ready  out  1  responder can accept a fetch this cycle.
- req_addr  in  ADDR_W  fetch address (PC).
- rsp_valid  out  1  rsp_instr/rsp_addr valid.
- rsp_ready  in  1  CPU consumes the response.
- rsp_instr  out  INSTR_W  fetched instruction.
- rsp_addr  out  ADDR_W  address the response belongs to.
- rsp_err  out  1  with rsp_valid: address ≥ DEPTH (rsp_instr forced to 0).
- load_en  in  1  write load_data to load_addr.
- load_addr  in  ADDR_W  load address.
- load_data  in  INSTR_W  load data.
- load_drop  out  1  one-cycle pulse: load_en was ignored (busy or out of range).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; req_ready=0 while in reset; rsp_valid=0; rsp_instr=0; rsp_addr=0; rsp_err=0; load_drop=0; wait counter=0.
  - All DEPTH memory words cleared to 0 (0 is NOP).
  - req_ready goes to 1 in the first cycle after deassertion.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = ~load_en.
  - Load has priority: if load_en and load_addr < DEPTH, mem[load_addr] ← load_data at the edge; if load_addr ≥ DEPTH, no write and load_drop=1 next cycle.
  - Fetch accepted when req_valid & req_ready. At the accepting edge, latch req_addr into the address register and load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - When counter==1, next state is RESP.
- Entry to RESP (registered at the edge):
  - rsp_instr = mem[addr], or 0 with rsp_err=1 if addr ≥ DEPTH.
  - rsp_addr = addr; rsp_valid=1.
- Latency: request accepted at the edge ending cycle N → rsp_valid first high in cycle N+1+WAIT_CYCLES.
- RESP:
  - rsp_valid, rsp_instr, rsp_addr and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge, go to IDLE with rsp_valid=0. No back-to-back overlap: the next request is accepted no earlier than the following cycle.
- load_en outside IDLE: ignored, no memory write, load_drop pulses for one cycle. Memory contents for an in-flight fetch therefore cannot change.
- req_valid outside IDLE: ignored (req_ready=0); the CPU must hold the request.
- Simultaneous load_en and req_valid in IDLE: the load wins and the request is stalled (req_ready=0) that cycle.
- Address wrap: none. Addresses are used as-is; ≥ DEPTH is the error path only.
- Reset mid-transaction: abandons WAIT/RESP immediately and drops the pending response. No response is ever issued for a pre-reset request.

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W and INSTR_W defaults.
  - NOP encoding (0).
  - FSM state encoding localparams IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- One natural sub-module, imem_array: DEPTH×INSTR_W register array with async clear, single write port and single combinational read port.
- The FSM, counter and handshake stay in imem_responder.

Test Plan:
1. Reset with WAIT_CYCLES=1. Load mem[3]=8'hA5 in IDLE; request addr 3 accepted in cycle N → rsp_valid high in cycle N+2 with rsp_instr=A5, rsp_addr=3, rsp_err=0.
2. WAIT_CYCLES=0: request addr 0 after reset → rsp_instr=00 in cycle N+1. Hold rsp_ready=0 for 3 cycles → outputs stable; req_ready=0 throughout.
3. DEPTH=12: request addr 13 → rsp_err=1, rsp_instr=00. Load to addr 14 → load_drop pulse, no write.
4. Assert load_en (addr 3, data 3C) during WAIT → load_drop=1; the response still returns the old value A5, and mem[3] stays A5.
5. load_en and req_valid together in IDLE → write happens, req_ready=0 that cycle; request accepted next cycle and returns the newly written data.
6. Drive reset=0 asynchronously mid-WAIT → rsp_valid=0 immediately, memory reads 00, and no response arrives after release.
